// File: rtl/brick_health_mgr.sv
// rtl/brick_health_mgr.sv - brick health store with init sweep and hit/decrement FSM
// Optional miss counter output enabled by defining BRICK_MISS_COUNT_EN.
module brick_health_mgr #(
  parameter int NUM_BRICKS  = 16,
  parameter int HEALTH_W    = 2,
  parameter int INIT_HEALTH = 2,
  localparam int IDX_W      = $clog2(NUM_BRICKS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init_start,
  input  logic                  hit_valid,
  input  logic [IDX_W-1:0]      hit_index,
  output logic                  hit_ready,
  output logic                  game_write,
  output logic [9:0]            total_health,
  output logic                  init_done,
  output logic [NUM_BRICKS-1:0] brick_alive,
  output logic                  brick_destroyed,
`ifdef BRICK_MISS_COUNT_EN
  output logic [7:0]            miss_count,
`endif
  output logic [IDX_W-1:0]      destroyed_index
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_CHECK, S_WRITE} state_t;

  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_BRICKS - 1);
  localparam logic [IDX_W:0]      NB       = (IDX_W + 1)'(NUM_BRICKS);
  localparam logic [HEALTH_W-1:0] INIT_H   = HEALTH_W'(INIT_HEALTH);
  localparam logic [9:0]          INIT_ADD = 10'(INIT_HEALTH);

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     init_idx;
  logic [IDX_W-1:0]     hit_idx;
  logic [HEALTH_W-1:0]  health [NUM_BRICKS];
  logic [HEALTH_W-1:0]  hit_health;
  logic                 hit_live;

  // Out-of-range indices behave exactly like a dead brick.
  assign hit_health = health[hit_idx];
  assign hit_live   = ({1'b0, hit_idx} < NB) && (hit_health != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_INIT;
    else       state <= state_nxt;
  end

  // init_start masks hit_ready so a simultaneous hit is never handshaken.
  always_comb begin
    state_nxt = state;
    hit_ready = 1'b0;
    init_done = 1'b1;
    case (state)
      S_INIT: begin
        init_done = 1'b0;
        if (init_idx == LAST_IDX) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        hit_ready = ~init_start;
        if (init_start)     state_nxt = S_INIT;
        else if (hit_valid) state_nxt = S_CHECK;
      end
      S_CHECK: state_nxt = hit_live ? S_WRITE : S_IDLE;
      S_WRITE: state_nxt = S_IDLE;
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_idx        <= '0;
      hit_idx         <= '0;
      total_health    <= '0;
      game_write      <= 1'b0;
      brick_destroyed <= 1'b0;
      destroyed_index <= '0;
      for (int i = 0; i < NUM_BRICKS; i++) health[i] <= '0;
    end else begin
      game_write      <= 1'b0;
      brick_destroyed <= 1'b0;
      case (state)
        S_INIT: begin
          health[init_idx] <= INIT_H;
          total_health     <= total_health + INIT_ADD;
          init_idx         <= (init_idx == LAST_IDX) ? '0 : init_idx + 1'b1;
        end
        S_IDLE: begin
          if (init_start) begin
            total_health <= '0;
            init_idx     <= '0;
          end else if (hit_valid) begin
            hit_idx <= hit_index;
          end
        end
        S_CHECK: begin
          // Pulse flops are loaded here so they are high exactly during WRITE.
          if (hit_live) begin
            health[hit_idx] <= hit_health - 1'b1;
            game_write      <= 1'b1;
            if (hit_health == HEALTH_W'(1)) begin
              brick_destroyed <= 1'b1;
              destroyed_index <= hit_idx;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    brick_alive = '0;
    for (int i = 0; i < NUM_BRICKS; i++) brick_alive[i] = |health[i];
  end

`ifdef BRICK_MISS_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                                  miss_count <= '0;
    else if (state == S_INIT)                                   miss_count <= '0;
    else if (state == S_CHECK && !hit_live && miss_count != 8'hFF) miss_count <= miss_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_brick_health_mgr.sv
// tb/tb_brick_health_mgr.sv - self-checking bench for brick_health_mgr with a queue-based health model
module tb_brick_health_mgr;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init_start = 1'b0;
  logic        hit_valid = 1'b0;
  logic [3:0]  hit_index = '0;
  logic        hit_ready;
  logic        game_write;
  logic [9:0]  total_health;
  logic        init_done;
  logic [15:0] brick_alive;
  logic        brick_destroyed;
  logic [3:0]  destroyed_index;
`ifdef BRICK_MISS_COUNT_EN
  logic [7:0]  miss_count;
`endif

  brick_health_mgr dut (
    .clk(clk), .reset(reset), .init_start(init_start),
    .hit_valid(hit_valid), .hit_index(hit_index), .hit_ready(hit_ready),
    .game_write(game_write), .total_health(total_health), .init_done(init_done),
    .brick_alive(brick_alive), .brick_destroyed(brick_destroyed),
`ifdef BRICK_MISS_COUNT_EN
    .miss_count(miss_count),
`endif
    .destroyed_index(destroyed_index)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int model [16];
  int acc_q[$];
  int gw_q[$];
  int bd_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled mid-cycle; tasks compare against it.
  always @(negedge clk) begin
    if (hit_valid && hit_ready) acc_q.push_back(cyc);
    if (game_write)             gw_q.push_back(cyc);
    if (brick_destroyed)        bd_q.push_back(cyc);
  end

  function automatic logic [15:0] model_alive();
    logic [15:0] a;
    for (int i = 0; i < 16; i++) a[i] = (model[i] > 0);
    return a;
  endfunction

  task automatic model_fill();
    for (int i = 0; i < 16; i++) model[i] = 2;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      n++;
      if (init_done) break;
    end
  endtask

  task automatic hit_once(input int idx);
    int  gw0, bd0, acc0;
    bit  exp_w, exp_d, got;
    exp_w = model[idx] > 0;
    if (exp_w) model[idx]--;
    exp_d = exp_w && (model[idx] == 0);
    gw0 = gw_q.size(); bd0 = bd_q.size(); acc0 = acc_q.size();
    hit_valid = 1'b1;
    hit_index = 4'(idx);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (acc_q.size() != acc0) begin got = 1'b1; break; end
    end
    hit_valid = 1'b0;
    checks++;
    if (!got) begin fails++; $display("FAIL hit_accept idx=%0d: not accepted within 20 cycles", idx); end
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (gw_q.size() - gw0 !== int'(exp_w)) begin
      fails++; $display("FAIL hit_write idx=%0d: pulses=%0d expected=%0d", idx, gw_q.size() - gw0, exp_w);
    end
    checks++;
    if (bd_q.size() - bd0 !== int'(exp_d)) begin
      fails++; $display("FAIL hit_destroy idx=%0d: pulses=%0d expected=%0d", idx, bd_q.size() - bd0, exp_d);
    end
    if (exp_w && gw_q.size() > gw0 && got) begin
      checks++;
      if (gw_q[$] !== acc_q[$] + 2) begin
        fails++; $display("FAIL hit_latency idx=%0d: write_cyc=%0d expected=%0d", idx, gw_q[$], acc_q[$] + 2);
      end
    end
    if (exp_d) begin
      checks++;
      if (destroyed_index !== 4'(idx)) begin
        fails++; $display("FAIL destroyed_index: got=%0d expected=%0d", destroyed_index, idx);
      end
    end
    checks++;
    if (brick_alive !== model_alive()) begin
      fails++; $display("FAIL brick_alive after hit %0d: got=%h expected=%h", idx, brick_alive, model_alive());
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({game_write, brick_destroyed, init_done, hit_ready} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags: got=%b expected=0000", {game_write, brick_destroyed, init_done, hit_ready});
    end
    checks++;
    if (total_health !== 10'd0 || brick_alive !== 16'h0 || destroyed_index !== 4'd0) begin
      fails++; $display("FAIL reset_values: total=%0d alive=%h didx=%0d expected 0", total_health, brick_alive, destroyed_index);
    end
    reset = 1'b0;
    wait_init(n);
    model_fill();
    checks++;
    if (n !== 16) begin fails++; $display("FAIL init_cycles: got=%0d expected=16", n); end
    checks++;
    if (total_health !== 10'd32) begin fails++; $display("FAIL init_total: got=%0d expected=32", total_health); end
    checks++;
    if (brick_alive !== 16'hFFFF) begin fails++; $display("FAIL init_alive: got=%h expected=ffff", brick_alive); end
    checks++;
    if (hit_ready !== 1'b1) begin fails++; $display("FAIL init_ready: got=%b expected=1", hit_ready); end
  endtask

  task automatic test_back_to_back();
    int acc0, gw0, bd0;
    acc0 = acc_q.size(); gw0 = gw_q.size(); bd0 = bd_q.size();
    hit_valid = 1'b1;
    hit_index = 4'd5;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (acc_q.size() >= acc0 + 2) break;
    end
    hit_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    model[5] = 0;
    checks++;
    if (acc_q.size() - acc0 !== 2) begin
      fails++; $display("FAIL b2b_accepts: got=%0d expected=2", acc_q.size() - acc0);
    end else begin
      checks++;
      if (acc_q[acc0 + 1] - acc_q[acc0] !== 3) begin
        fails++; $display("FAIL b2b_spacing: got=%0d expected=3", acc_q[acc0 + 1] - acc_q[acc0]);
      end
    end
    checks++;
    if (gw_q.size() - gw0 !== 2 || bd_q.size() - bd0 !== 1) begin
      fails++; $display("FAIL b2b_pulses: writes=%0d destroys=%0d expected=2,1", gw_q.size() - gw0, bd_q.size() - bd0);
    end else begin
      checks++;
      if (bd_q[bd0] !== gw_q[gw0 + 1] || gw_q[gw0 + 1] - gw_q[gw0] !== 3) begin
        fails++; $display("FAIL b2b_timing: destroy_cyc=%0d writes=%0d,%0d expected destroy on second write, 3 apart",
                          bd_q[bd0], gw_q[gw0], gw_q[gw0 + 1]);
      end
    end
    checks++;
    if (destroyed_index !== 4'd5) begin fails++; $display("FAIL b2b_index: got=%0d expected=5", destroyed_index); end
    checks++;
    if (brick_alive !== model_alive()) begin
      fails++; $display("FAIL b2b_alive: got=%h expected=%h", brick_alive, model_alive());
    end
  endtask

  task automatic test_dead_hit();
    hit_once(5);
`ifdef BRICK_MISS_COUNT_EN
    checks++;
    if (miss_count !== 8'd1) begin fails++; $display("FAIL miss_count: got=%0d expected=1", miss_count); end
`endif
  endtask

  task automatic test_init_priority();
    int acc0, gw0, n;
    acc0 = acc_q.size(); gw0 = gw_q.size();
    init_start = 1'b1;
    hit_valid  = 1'b1;
    hit_index  = 4'd3;
    @(posedge clk); #1;
    init_start = 1'b0;
    hit_valid  = 1'b0;
    checks++;
    if (init_done !== 1'b0 || total_health !== 10'd0) begin
      fails++; $display("FAIL prio_enter_init: init_done=%b total=%0d expected 0,0", init_done, total_health);
    end
    wait_init(n);
    model_fill();
    checks++;
    if (acc_q.size() !== acc0 || gw_q.size() !== gw0) begin
      fails++; $display("FAIL prio_no_hit: accepts=%0d writes=%0d expected 0,0", acc_q.size() - acc0, gw_q.size() - gw0);
    end
    checks++;
    if (n !== 16 || total_health !== 10'd32 || brick_alive !== 16'hFFFF) begin
      fails++; $display("FAIL prio_reinit: cycles=%0d total=%0d alive=%h expected 16,32,ffff", n, total_health, brick_alive);
    end
  endtask

  task automatic test_random_hits();
    for (int k = 0; k < 40; k++) hit_once(int'($urandom_range(15, 0)));
  endtask

  task automatic test_reset_in_check();
    int gw0, acc0, n;
    gw0 = gw_q.size(); acc0 = acc_q.size();
    hit_valid = 1'b1;
    hit_index = 4'(int'($urandom_range(15, 0)));
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (acc_q.size() != acc0) break;
    end
    hit_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if ({game_write, init_done, hit_ready, brick_destroyed} !== 4'b0000 || total_health !== 10'd0 || brick_alive !== 16'h0) begin
      fails++; $display("FAIL rst_check_outputs: gw=%b done=%b ready=%b bd=%b total=%0d alive=%h expected all 0",
                        game_write, init_done, hit_ready, brick_destroyed, total_health, brick_alive);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    wait_init(n);
    model_fill();
    checks++;
    if (gw_q.size() !== gw0) begin fails++; $display("FAIL rst_check_pulse: writes=%0d expected=0", gw_q.size() - gw0); end
    checks++;
    if (n !== 16 || total_health !== 10'd32 || brick_alive !== 16'hFFFF) begin
      fails++; $display("FAIL rst_check_reinit: cycles=%0d total=%0d alive=%h expected 16,32,ffff", n, total_health, brick_alive);
    end
  endtask

  task automatic test_all_bricks();
    int order[32];
    int gw0, bd0, j, t;
    for (int i = 0; i < 32; i++) order[i] = i % 16;
    for (int i = 31; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    gw0 = gw_q.size(); bd0 = bd_q.size();
    for (int i = 0; i < 32; i++) hit_once(order[i]);
    checks++;
    if (gw_q.size() - gw0 !== 32 || bd_q.size() - bd0 !== 16) begin
      fails++; $display("FAIL all_pulses: writes=%0d destroys=%0d expected 32,16", gw_q.size() - gw0, bd_q.size() - bd0);
    end
    checks++;
    if (brick_alive !== 16'h0) begin fails++; $display("FAIL all_alive: got=%h expected=0", brick_alive); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_dead_hit();
    test_init_priority();
    test_random_hits();
    test_reset_in_check();
    test_all_bricks();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/brick_health_mgr.md
BRICK_HEALTH_MGR -- requirements
Module: brick_health_mgr

Interface
REQ-001 Parameter NUM_BRICKS, default 16, number of bricks held; range 2..64.
REQ-002 Parameter HEALTH_W, default 2, width of each brick's health field.
REQ-003 Parameter INIT_HEALTH, default 2, health loaded into every brick at init; range 1..2^HEALTH_W-1; NUM_BRICKS*INIT_HEALTH SHALL be at most 1023.
REQ-004 Port clk, input, 1, the single clock; all state on rising edge.
REQ-005 Port reset, input, 1, asynchronous active-high reset.
REQ-006 Port init_start, input, 1, request to reload all bricks (level-sampled in IDLE).
REQ-007 Port hit_valid, input, 1, ball-collision request valid.
REQ-008 Port hit_index, input, IDX_W = clog2(NUM_BRICKS), index of brick hit.
REQ-009 Port hit_ready, output, 1, request accepted when hit_valid and hit_ready are both high at a rising edge.
REQ-010 Port game_write, output, 1, registered one-cycle pulse per health point removed; glitch-free, drives a downstream edge-clocked health counter.
REQ-011 Port total_health, output, 10, sum of all brick health loaded at init.
REQ-012 Port init_done, output, 1, high while the brick field is valid.
REQ-013 Port brick_alive, output, NUM_BRICKS, bit i high when brick i health is non-zero.
REQ-014 Port brick_destroyed, output, 1, one-cycle pulse coincident with the game_write that takes a brick to zero.
REQ-015 Port destroyed_index, output, IDX_W, index of the last destroyed brick; held until the next destruction.

Function
REQ-016 The FSM SHALL have states INIT, IDLE, CHECK, WRITE.
REQ-017 INIT: one brick per cycle, index 0..NUM_BRICKS-1, is loaded with INIT_HEALTH and INIT_HEALTH is added to total_health; after the last brick, go to IDLE. INIT therefore lasts NUM_BRICKS cycles.
REQ-018 init_done SHALL be 0 in INIT and 1 otherwise; total_health SHALL be stable whenever init_done is 1.
REQ-019 IDLE: hit_ready = 1. init_start has priority: if init_start is high, go to INIT with total_health cleared to 0 and no hit accepted. Otherwise, on handshake, latch hit_index and go to CHECK.
REQ-020 hit_ready SHALL be 0 in INIT, CHECK and WRITE.
REQ-021 CHECK: if the latched brick's health is 0, return to IDLE with no pulse. Otherwise decrement that brick's health by 1 and go to WRITE.
REQ-022 WRITE: game_write = 1 for exactly this cycle, i.e. two cycles after the accept edge. If the new health is 0, brick_destroyed = 1 and destroyed_index updates. Then go to IDLE.
REQ-023 Health arithmetic SHALL never wrap below 0; an out-of-range hit_index (>= NUM_BRICKS) is treated as a dead brick.
REQ-024 brick_alive SHALL reflect the stored health combinationally from registers, updating at the decrement edge.
REQ-025 init_start in CHECK or WRITE SHALL be ignored until IDLE; a pending WRITE pulse still completes.
REQ-026 game_write and brick_destroyed SHALL be driven directly from flops.

Reset
REQ-027 While reset is high: state = INIT, init index = 0, total_health = 0, all brick health = 0, game_write = 0, brick_destroyed = 0, destroyed_index = 0, init_done = 0, hit_ready = 0.
REQ-028 After reset deasserts, INIT SHALL run automatically without init_start.
REQ-029 Reset asserted mid-CHECK or mid-WRITE SHALL abort the operation, with no game_write pulse.

Configuration
REQ-030 Macro BRICK_MISS_COUNT_EN: when defined, add output miss_count (8 bits, reset 0, cleared in INIT), incremented in CHECK for each hit on a zero-health or out-of-range brick and saturating at 255. When undefined, the port and its logic are absent and behaviour is otherwise identical.

Verification
REQ-031 Reset release with defaults -> init_done rises after 16 cycles; total_health = 32; brick_alive = 0xFFFF; hit_ready = 1.
REQ-032 Hit brick 5 twice, back-to-back valid -> accepts 3 cycles apart; two single-cycle game_write pulses; second pulse coincides with brick_destroyed = 1 and destroyed_index = 5; brick_alive bit 5 = 0.
REQ-033 Third hit on brick 5 -> no game_write; with BRICK_MISS_COUNT_EN, miss_count = 1.
REQ-034 init_start and hit_valid both high in IDLE -> hit not accepted; INIT runs; total_health returns to 32 and all bricks are alive.
REQ-035 reset asserted during CHECK -> no game_write pulse; outputs at reset values immediately; re-init completes.
REQ-036 Hit all 16 bricks twice each -> exactly 32 game_write pulses and 16 brick_destroyed pulses; brick_alive = 0.
